// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, status flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_ext #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [$clog2(FIFO_DEPTH)-1:0] wrptr,
  output logic [$clog2(FIFO_DEPTH)-1:0] rdptr,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [CW-1:0] countQ, countD;
  logic          overflowQ, underflowQ;
  logic          wrAccept, rdAccept;

  assign empty        = (countQ == '0);
  assign full         = (countQ == CW'(FIFO_DEPTH));
  assign almost_full  = (countQ >= CW'(AF_THRESH));
  assign almost_empty = (countQ <= CW'(AE_THRESH));

  // A write into a full FIFO still lands when the same cycle frees a slot.
  assign rdAccept = rd_en && !empty;
  assign wrAccept = wr_en && (!full || rdAccept);

  always_comb begin
    countD = countQ;
    unique case ({wrAccept, rdAccept})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ     <= '0;
      rdPtrQ     <= '0;
      countQ     <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (wrAccept) wrPtrQ <= wrPtrQ + AW'(1);
      if (rdAccept) rdPtrQ <= rdPtrQ + AW'(1);
      countQ     <= countD;
      overflowQ  <= wr_en && !wrAccept;
      underflowQ <= rd_en && !rdAccept;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) mem[wrPtrQ] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rdPtrQ];
`else
  logic [FIFO_WIDTH-1:0] dataOutQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOutQ <= '0;
    end else if (rdAccept) begin
      dataOutQ <= mem[rdPtrQ];
    end
  end

  assign data_out = dataOutQ;
`endif

  assign count     = countQ;
  assign wrptr     = wrPtrQ;
  assign rdptr     = rdPtrQ;
  assign overflow  = overflowQ;
  assign underflow = underflowQ;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: a queue-based model predicts each cycle's outputs,
// a monitor compares them after every rising edge. Honours FIFO_FWFT_EN.
module tb_sync_fifo_ext;

  localparam int Width = 8;
  localparam int Depth = 32;
  localparam int AfTh  = 28;
  localparam int AeTh  = 4;

  logic             clk = 1'b0;
  logic             rst, wr_en, rd_en;
  logic [Width-1:0] data_in, data_out;
  logic             empty, full, almost_full, almost_empty, overflow, underflow;
  logic [5:0]       count;
  logic [4:0]       wrptr, rdptr;

  sync_fifo_ext #(
    .FIFO_WIDTH(Width),
    .FIFO_DEPTH(Depth),
    .AF_THRESH (AfTh),
    .AE_THRESH (AeTh)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .wrptr       (wrptr),
    .rdptr       (rdptr),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    bit emp, ful, af, ae, ovf, unf;
    int wp, rp;
    bit chkDout;
    int dout;
  } exp_t;

  exp_t expQ[$];
  int   model[$];
  int   mWp, mRp, mLast;
  int   cyc;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, c, act, exp);
    end
  endtask

  // Drive one cycle and predict the state visible after the coming rising edge.
  task automatic step(input bit r, input bit we, input bit re, input int din);
    exp_t e;
    bit   rdOk, wrOk;
    rst = r; wr_en = we; rd_en = re; data_in = din[Width-1:0];
    e.ovf = 0; e.unf = 0;
    if (r) begin
      model.delete();
      mWp = 0; mRp = 0; mLast = 0;
    end else begin
      rdOk = re && model.size() > 0;
      wrOk = we && (model.size() < Depth || rdOk);
      e.ovf = we && !wrOk;
      e.unf = re && !rdOk;
      if (rdOk) begin
        mLast = model.pop_front();
        mRp   = (mRp + 1) % Depth;
      end
      if (wrOk) begin
        model.push_back(din & 'hFF);
        mWp = (mWp + 1) % Depth;
      end
    end
    e.cyc = cyc;
    e.cnt = model.size();
    e.emp = (e.cnt == 0);
    e.ful = (e.cnt == Depth);
    e.af  = (e.cnt >= AfTh);
    e.ae  = (e.cnt <= AeTh);
    e.wp  = mWp;
    e.rp  = mRp;
`ifdef FIFO_FWFT_EN
    e.chkDout = !e.emp;
    e.dout    = e.emp ? 0 : model[0];
`else
    e.chkDout = 1;
    e.dout    = mLast;
`endif
    expQ.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("count", e.cyc, 32'(count), e.cnt);
        chk("empty", e.cyc, 32'(empty), 32'(e.emp));
        chk("full", e.cyc, 32'(full), 32'(e.ful));
        chk("almost_full", e.cyc, 32'(almost_full), 32'(e.af));
        chk("almost_empty", e.cyc, 32'(almost_empty), 32'(e.ae));
        chk("overflow", e.cyc, 32'(overflow), 32'(e.ovf));
        chk("underflow", e.cyc, 32'(underflow), 32'(e.unf));
        chk("wrptr", e.cyc, 32'(wrptr), e.wp);
        chk("rdptr", e.cyc, 32'(rdptr), e.rp);
        if (e.chkDout) chk("data_out", e.cyc, 32'(data_out), e.dout);
      end
    end
  end

  initial begin
    int wp;
    cyc = 0;
    rst = 1; wr_en = 0; rd_en = 0; data_in = '0;

    // Reset with a write request held high.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 'h77);

    // Fill 0x00..0x1F, then a rejected write; idle cycle confirms a one-cycle pulse.
    for (int i = 0; i < Depth; i++) step(0, 1, 0, i);
    step(0, 1, 0, 'hAA);
    step(0, 0, 0, 0);

    // Drain in order; the 33rd read underflows.
    for (int i = 0; i <= Depth; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Alternating write/read so both pointers wrap.
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 'h80 + i);
      step(0, 0, 1, 0);
    end

    // Simultaneous access at full and at empty.
    for (int i = 0; i < Depth; i++) step(0, 1, 0, $urandom_range(0, 255));
    step(0, 1, 1, 'h55);
    step(0, 0, 0, 0);
    while (model.size() > 0) step(0, 0, 1, 0);
    step(0, 1, 1, 'h66);
    step(0, 0, 0, 0);

    // Read latency of a single word.
    step(0, 0, 1, 0);
    step(0, 1, 0, 'h3C);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Random traffic in phases biased toward filling or draining, with rare resets.
    for (int ph = 0; ph < 40; ph++) begin
      wp = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 64; i++) begin
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < (105 - wp),
             $urandom_range(0, 255));
      end
    end

    // Mid-operation reset discards contents.
    for (int i = 0; i < 10; i++) step(0, 1, 0, i + 1);
    step(1, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, number of entries (power of two, >=4).
REQ-003 SHALL have parameter AF_THRESH, default FIFO_DEPTH-4, almost_full level (1..FIFO_DEPTH-1).
REQ-004 SHALL have parameter AE_THRESH, default 4, almost_empty level (1..FIFO_DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port rd_en  input  1  read request.
REQ-009 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-010 SHALL have port data_out  output  FIFO_WIDTH  read data.
REQ-011 SHALL have ports empty, full, almost_full, almost_empty  output  1 each  status flags.
REQ-012 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 SHALL have ports wrptr, rdptr  output  $clog2(FIFO_DEPTH) each  write/read pointers.
REQ-014 SHALL have ports overflow, underflow  output  1 each  rejected-request pulses.

Function
REQ-015 SHALL accept a write when wr_en=1 and (full=0 or an accepted read occurs the same cycle): mem[wrptr]<=data_in, wrptr increments.
REQ-016 SHALL accept a read when rd_en=1 and empty=0: rdptr increments.
REQ-017 SHALL wrap wrptr and rdptr from FIFO_DEPTH-1 to 0.
REQ-018 SHALL update count +1 (write only), -1 (read only), unchanged (both or neither), never leaving 0..FIFO_DEPTH.
REQ-019 SHALL derive empty=(count==0), full=(count==FIFO_DEPTH), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH), all from registered count.
REQ-020 SHALL, on full with wr_en=1 and rd_en=1, accept both; count stays FIFO_DEPTH; no overflow.
REQ-021 SHALL, on empty with wr_en=1 and rd_en=1, accept the write only; count becomes 1; underflow pulses.
REQ-022 SHALL pulse overflow high for exactly the cycle after a rejected write; memory, wrptr, count unchanged.
REQ-023 SHALL pulse underflow high for exactly the cycle after a rejected read; rdptr, count, data_out unchanged.
REQ-024 SHALL preserve data order: words read in exactly the order written, no loss or duplication.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set wrptr=0, rdptr=0, count=0, data_out=0, overflow=0, underflow=0, ignoring wr_en/rd_en.
REQ-026 SHALL give post-reset flags empty=1, full=0, almost_empty=1, almost_full=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored contents; memory array itself need not be cleared.

Configuration
REQ-028 SHALL support macro FIFO_FWFT_EN selecting read mode.
REQ-029 SHALL, without FIFO_FWFT_EN (standard mode), register data_out<=mem[rdptr] on an accepted read (1-cycle latency); data_out holds otherwise.
REQ-030 SHALL, with FIFO_FWFT_EN (first-word-fall-through), drive data_out=mem[rdptr] combinationally whenever empty=0; accepted read pops head, next word visible same cycle the pointer advances; data_out is don't-care while empty and reset value requirement on data_out is waived.

Verification
REQ-031 SHALL check reset: drive wr_en=1 with rst=1 for 3 cycles -> count=0, empty=1, wrptr=0, data_out=0.
REQ-032 SHALL check fill/overflow: write 0x00..0x1F (depth 32) then one more write 0xAA -> full=1, count=32, overflow pulses 1 cycle, almost_full rose at count=28.
REQ-033 SHALL check drain/underflow: from full, read 33 times -> data 0x00..0x1F in order, 33rd read gives underflow pulse, empty=1, almost_empty rose at count=4.
REQ-034 SHALL check wrap: 40 alternating write/read of incrementing data -> pointers wrap 31->0, all data matches, count stays 0..1.
REQ-035 SHALL check simultaneous access: at full, wr_en=rd_en=1 with 0x55 -> count stays 32, no overflow; at empty, wr_en=rd_en=1 with 0x66 -> count=1, underflow pulses.
REQ-036 SHALL check read latency in both builds: write 0x3C to empty FIFO -> FWFT: data_out=0x3C as soon as empty=0; standard: data_out=0x3C the cycle after rd_en accepted.
